// File: rtl/frame_former_par_pkg.sv
// frame_former_par_pkg: shared FSM state encoding and sizing helper for the frame former.
//   state_t        - frame section currently being emitted
//   words_to_bits  - converts a word count to a bit width
package frame_former_par_pkg;

    typedef enum logic [1:0] {PREAMBLE, HEADER, PAYLOAD, PAD} state_t;

    function automatic int words_to_bits(input int words, input int width);
        return words * width;
    endfunction

endpackage

// File: rtl/frame_former_par_if.sv
// frame_former_par_if: input-FIFO read port and output-FIFO write port of the frame former.
//   FIFO_IN_DATA/FIFO_IN_RE/FIFO_IN_EMPTY    - input FIFO (data valid the cycle after RE)
//   FIFO_OUT_DATA/FIFO_OUT_WE/FIFO_OUT_FULL  - output FIFO
//   master: frame former side, slave: FIFO side
interface frame_former_par_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] FIFO_IN_DATA;
    logic              FIFO_IN_RE;
    logic              FIFO_IN_EMPTY;
    logic [DATA_W-1:0] FIFO_OUT_DATA;
    logic              FIFO_OUT_WE;
    logic              FIFO_OUT_FULL;

    modport master (
        input  FIFO_IN_DATA, FIFO_IN_EMPTY, FIFO_OUT_FULL,
        output FIFO_IN_RE, FIFO_OUT_DATA, FIFO_OUT_WE
    );

    modport slave (
        output FIFO_IN_DATA, FIFO_IN_EMPTY, FIFO_OUT_FULL,
        input  FIFO_IN_RE, FIFO_OUT_DATA, FIFO_OUT_WE
    );
endinterface

// File: rtl/frame_skid_buf.sv
// frame_skid_buf: 2-entry holding FIFO for payload words returned by the input FIFO.
//   CLK, RESET_N     - clock, synchronous active-low reset (empties the buffer)
//   push, push_data  - store a word
//   pop              - discard the head word
//   head, count      - head word and occupancy (0..2)
module frame_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/frame_former_par.sv
// frame_former_par: builds preamble/header/payload frames from an input FIFO into an output FIFO.
//   CLK, RESET_N  - clock, synchronous active-low reset
//   bus           - input/output FIFO ports (frame_former_par_if.master)
//   FRAME_DONE    - pulse on the write of the last word of a frame
//   PAD_ACTIVE    - high while the current frame is being padded
//   SEQ_NUM       - sequence number of the current/next frame
module frame_former_par
    import frame_former_par_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int PREAMBLE_WORDS = 4,
    parameter logic [words_to_bits(PREAMBLE_WORDS, DATA_W)-1:0] PREAMBLE_VAL = 'h7E7E7E7E,
    parameter int PAYLOAD_WORDS  = 48,
    parameter int HDR_EN         = 1,
    parameter int PAD_TIMEOUT    = 64,
    parameter logic [DATA_W-1:0] PAD_VAL = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    frame_former_par_if.master bus,
    output logic              FRAME_DONE,
    output logic              PAD_ACTIVE,
    output logic [DATA_W-1:0] SEQ_NUM
);
    localparam int CW = $clog2((PREAMBLE_WORDS > PAYLOAD_WORDS ? PREAMBLE_WORDS : PAYLOAD_WORDS) + 1);
    localparam int RW = $clog2(PAYLOAD_WORDS + 1);
    localparam int IW = $clog2(PAD_TIMEOUT + 2);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     rd_cnt;
    logic [IW-1:0]     idle_cnt;
    logic              in_flight;
    logic [1:0]        buf_cnt;
    logic [DATA_W-1:0] buf_head;
    logic              avail;
    logic              we;
    logic              re;
    logic              last;
    logic              idle;

    frame_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .push      (in_flight),
        .push_data (bus.FIFO_IN_DATA),
        .pop       (we && state == PAYLOAD),
        .head      (buf_head),
        .count     (buf_cnt)
    );

    // Reads are throttled so the buffer can always absorb every word already requested.
    always_comb begin
        avail = state != PAYLOAD || buf_cnt != 2'd0;
        we    = RESET_N && !bus.FIFO_OUT_FULL && avail;
        last  = (state == PAYLOAD || state == PAD) && cnt == CW'(PAYLOAD_WORDS - 1);
        re    = RESET_N && !bus.FIFO_IN_EMPTY && state != PAD && rd_cnt < RW'(PAYLOAD_WORDS)
                && 3'(buf_cnt) + 3'(in_flight) <= 3'(we && state == PAYLOAD) + 3'd1;
        idle  = state == PAYLOAD && buf_cnt == 2'd0 && !in_flight && bus.FIFO_IN_EMPTY;
        bus.FIFO_OUT_WE   = we;
        bus.FIFO_IN_RE    = re;
        FRAME_DONE        = we && last;
        bus.FIFO_OUT_DATA = !RESET_N          ? '0 :
                            state == PREAMBLE ? PREAMBLE_VAL[words_to_bits(int'(cnt), DATA_W) +: DATA_W] :
                            state == HEADER   ? SEQ_NUM :
                            state == PAYLOAD  ? buf_head : PAD_VAL;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= PREAMBLE;
            cnt        <= '0;
            rd_cnt     <= '0;
            idle_cnt   <= '0;
            in_flight  <= 1'b0;
            SEQ_NUM    <= '0;
            PAD_ACTIVE <= 1'b0;
        end else begin
            in_flight <= re;
            rd_cnt    <= FRAME_DONE ? '0 : rd_cnt + RW'(re);
            idle_cnt  <= idle ? idle_cnt + 1'b1 : '0;
            // Idle implies an empty buffer, so this never coincides with a payload write.
            if (PAD_TIMEOUT != 0 && idle && idle_cnt == IW'(PAD_TIMEOUT - 1)) begin
                state      <= PAD;
                PAD_ACTIVE <= 1'b1;
                idle_cnt   <= '0;
            end
            if (we) begin
                case (state)
                    PREAMBLE: begin
                        cnt <= cnt == CW'(PREAMBLE_WORDS - 1) ? '0 : cnt + 1'b1;
                        if (cnt == CW'(PREAMBLE_WORDS - 1))
                            state <= HDR_EN != 0 ? HEADER : PAYLOAD;
                    end
                    HEADER: state <= PAYLOAD;
                    default: begin
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last) begin
                            state      <= PREAMBLE;
                            SEQ_NUM    <= SEQ_NUM + 1'b1;
                            PAD_ACTIVE <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_frame_former_par.sv
// tb_frame_former_par: scoreboard bench for frame_former_par with default parameters.
module tb_frame_former_par;
    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       FRAME_DONE;
    logic       PAD_ACTIVE;
    logic [7:0] SEQ_NUM;

    frame_former_par_if #(.DATA_W(8)) bus ();

    frame_former_par dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .bus        (bus.master),
        .FRAME_DONE (FRAME_DONE),
        .PAD_ACTIVE (PAD_ACTIVE),
        .SEQ_NUM    (SEQ_NUM)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       pad;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_wr = 0;
    int         rd_cnt_tb = 0;
    int         src_limit = 1 << 30;
    int         src_next = 0;
    logic [7:0] seq_exp = 8'h00;
    bit         open = 1'b1;
    bit         toggle = 1'b0;

    function automatic logic [7:0] src_word(input int n);
        return 8'(n * 37 + 11);
    endfunction

    // Input FIFO model: an endless numbered word source, cut off at src_limit.
    assign bus.FIFO_IN_EMPTY = rd_cnt_tb >= src_limit;

    always @(posedge CLK) begin
        if (bus.FIFO_IN_RE === 1'b1) begin
            n_cmp++;
            if (bus.FIFO_IN_EMPTY !== 1'b0) begin
                n_bad++;
                $display("FAIL read_while_empty: got RE=1 with EMPTY=%b, want EMPTY=0", bus.FIFO_IN_EMPTY);
            end
            bus.FIFO_IN_DATA <= src_word(rd_cnt_tb);
            rd_cnt_tb <= rd_cnt_tb + 1;
        end
    end

    // Output FIFO: accepts only while expectations are pending, optionally toggling FULL.
    always @(posedge CLK) begin
        #1;
        bus.FIFO_OUT_FULL = (exp_q.size() == 0 && !open) ? 1'b1 : toggle ? ~bus.FIFO_OUT_FULL : 1'b0;
    end

    always @(negedge CLK) begin
        exp_t e;
        if (bus.FIFO_OUT_WE === 1'b1) begin
            n_wr++;
            n_cmp++;
            if (bus.FIFO_OUT_FULL !== 1'b0) begin
                n_bad++;
                $display("FAIL we_while_full: got FULL=%b with WE=1, want FULL=0", bus.FIFO_OUT_FULL);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got d=%h, want no write", bus.FIFO_OUT_DATA);
            end else begin
                e = exp_q.pop_front();
                if ({bus.FIFO_OUT_DATA, FRAME_DONE, PAD_ACTIVE} !== {e.d, e.last, e.pad}) begin
                    n_bad++;
                    $display("FAIL out_word: got d=%h done=%b pad=%b, want d=%h done=%b pad=%b",
                             bus.FIFO_OUT_DATA, FRAME_DONE, PAD_ACTIVE, e.d, e.last, e.pad);
                end
            end
        end else begin
            n_cmp++;
            if (FRAME_DONE !== 1'b0) begin
                n_bad++;
                $display("FAIL done_without_write: got FRAME_DONE=%b, want 0", FRAME_DONE);
            end
        end
    end

    task automatic push_frame(input int n_real);
        for (int i = 0; i < 4; i++)
            exp_q.push_back(exp_t'{8'h7E, 1'b0, 1'b0});
        exp_q.push_back(exp_t'{seq_exp, 1'b0, 1'b0});
        for (int i = 0; i < 48; i++)
            exp_q.push_back(exp_t'{i < n_real ? src_word(src_next + i) : 8'h00, i == 47, i >= n_real});
        seq_exp++;
        src_next += n_real;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        RESET_N = 1'b0;
        open = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (bus.FIFO_OUT_WE !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus.FIFO_OUT_WE); end
        n_cmp++;
        if (bus.FIFO_IN_RE !== 1'b0) begin n_bad++; $display("FAIL reset_re: got %b want 0", bus.FIFO_IN_RE); end
        n_cmp++;
        if (bus.FIFO_OUT_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.FIFO_OUT_DATA); end
        n_cmp++;
        if (PAD_ACTIVE !== 1'b0) begin n_bad++; $display("FAIL reset_pad: got %b want 0", PAD_ACTIVE); end
        n_cmp++;
        if (SEQ_NUM !== 8'h00) begin n_bad++; $display("FAIL reset_seq: got %h want 00", SEQ_NUM); end
        push_frame(48);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        open = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (bus.FIFO_OUT_WE !== 1'b1) begin n_bad++; $display("FAIL first_write_latency: got WE=%b want 1", bus.FIFO_OUT_WE); end
        drain(200, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL frame0_drain: got timeout=1 want 0"); end
        n_cmp++;
        if (SEQ_NUM !== 8'h01) begin n_bad++; $display("FAIL frame0_seq: got %h want 01", SEQ_NUM); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        push_frame(48);
        push_frame(48);
        drain(300, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_drain: got timeout=1 want 0"); end
        n_cmp++;
        if (SEQ_NUM !== 8'h03) begin n_bad++; $display("FAIL b2b_seq: got %h want 03", SEQ_NUM); end
    endtask

    task automatic test_full_toggle;
        bit ok;
        toggle = 1'b1;
        push_frame(48);
        drain(400, ok);
        toggle = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL toggle_drain: got timeout=1 want 0"); end
        n_cmp++;
        if (SEQ_NUM !== 8'h04) begin n_bad++; $display("FAIL toggle_seq: got %h want 04", SEQ_NUM); end
    endtask

    task automatic test_pad;
        bit ok;
        int gaps;
        src_limit = src_next + 10;
        push_frame(10);
        gaps = 0;
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            if (bus.FIFO_OUT_FULL === 1'b0 && bus.FIFO_OUT_WE === 1'b0)
                gaps++;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL pad_drain: got timeout=1 want 0"); end
        n_cmp++;
        if (gaps !== 64) begin n_bad++; $display("FAIL pad_timeout_gap: got %0d idle cycles want 64", gaps); end
        n_cmp++;
        if (PAD_ACTIVE !== 1'b0) begin n_bad++; $display("FAIL pad_clear: got %b want 0", PAD_ACTIVE); end
        src_limit = 1 << 30;
        push_frame(48);
        drain(200, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL post_pad_drain: got timeout=1 want 0"); end
        n_cmp++;
        if (SEQ_NUM !== 8'h06) begin n_bad++; $display("FAIL post_pad_seq: got %h want 06", SEQ_NUM); end
    endtask

    task automatic test_seq_wrap;
        bit ok;
        int n;
        n = 257 - int'(seq_exp);
        for (int i = 0; i < n; i++)
            push_frame(48);
        drain(16000, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_drain: got timeout=1 want 0"); end
        n_cmp++;
        if (SEQ_NUM !== 8'h01) begin n_bad++; $display("FAIL wrap_seq: got %h want 01", SEQ_NUM); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int base;
        base = n_wr;
        push_frame(48);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge CLK);
            #1;
            if (n_wr >= base + 25) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL mid_reach_word20: got timeout=1 want 0"); end
        open = 1'b1;
        exp_q.delete();
        RESET_N = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_cmp++;
            if ({bus.FIFO_OUT_WE, bus.FIFO_IN_RE, FRAME_DONE} !== 3'b000) begin
                n_bad++;
                $display("FAIL mid_reset_quiet: got we/re/done=%b%b%b want 000", bus.FIFO_OUT_WE, bus.FIFO_IN_RE, FRAME_DONE);
            end
        end
        @(posedge CLK);
        #1;
        seq_exp = 8'h00;
        src_next = rd_cnt_tb;
        push_frame(48);
        RESET_N = 1'b1;
        open = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (bus.FIFO_OUT_WE !== 1'b1) begin n_bad++; $display("FAIL mid_restart_latency: got WE=%b want 1", bus.FIFO_OUT_WE); end
        drain(200, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL mid_restart_drain: got timeout=1 want 0"); end
        n_cmp++;
        if (SEQ_NUM !== 8'h01) begin n_bad++; $display("FAIL mid_restart_seq: got %h want 01", SEQ_NUM); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_toggle();
        test_pad();
        test_seq_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
